show: RTL and testbench

- Debug front-panel driver for the pipelined MIPS core.
- Takes slide-switch settings and produces the register/memory probe address and view select that go to the core.
- Takes the core's debug words (cycle count, probed register, probed memory word, per-stage instruction words, per-stage status flags).
- Drives an 8-digit multiplexed, active-low 7-segment display plus 16 LEDs.

---
 rtl/show.sv | 157 +++++++++++++++
 tb/tb_show.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/show.sv
// Front-panel driver for the pipelined MIPS core: 8-digit multiplexed 7-seg scan, LED page mux, probe wiring.
// Optional macro SHOW_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module show #(
  parameter int REFRESH_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] s,
  input  logic [31:0] clkinfo,
  input  logic [31:0] reginfo,
  input  logic [31:0] meminfo,
  input  logic [31:0] fetchd,
  input  logic [31:0] decoded,
  input  logic [31:0] executed,
  input  logic [31:0] memoryd,
  input  logic [31:0] writebackd,
  input  logic [15:0] signF,
  input  logic [15:0] signD,
  input  logic [15:0] signE,
  input  logic [15:0] signM,
  input  logic [15:0] signW,
  output logic [6:0]  adds,
  output logic [2:0]  select,
  output logic [15:0] l,
  output logic [7:0]  en,
  output logic [6:0]  c
);

  localparam logic [15:0] PRE_TC = 16'(REFRESH_DIV - 1);

  logic [15:0] r_pre;
  logic [2:0]  r_idx;
  logic [31:0] r_frame;
  logic        r_live;
  logic [7:0]  r_en;
  logic [6:0]  r_c;
  logic [15:0] r_l;

  logic [31:0] w_word;
  logic [15:0] w_pre_nxt;
  logic [2:0]  w_idx_nxt;
  logic [31:0] w_frame_nxt;
  logic [3:0]  w_nib;
  logic [6:0]  w_seg;
  logic        w_blank;
  logic [15:0] w_l_nxt;

  assign adds   = s[10:4];
  assign select = s[3:1];
  assign l      = r_l;
  assign en     = r_en;
  assign c      = r_c;

  always_comb begin
    case (select)
      3'd0:    w_word = clkinfo;
      3'd1:    w_word = reginfo;
      3'd2:    w_word = meminfo;
      3'd3:    w_word = fetchd;
      3'd4:    w_word = decoded;
      3'd5:    w_word = executed;
      3'd6:    w_word = memoryd;
      default: w_word = writebackd;
    endcase
  end

  // First live cycle after reset counts as entering digit 0, so the frame is latched there too.
  always_comb begin
    w_pre_nxt   = r_pre;
    w_idx_nxt   = r_idx;
    w_frame_nxt = r_frame;
    if (!r_live) begin
      w_pre_nxt   = 16'd0;
      w_idx_nxt   = 3'd0;
      w_frame_nxt = w_word;
    end else if (r_pre == PRE_TC) begin
      w_pre_nxt = 16'd0;
      w_idx_nxt = r_idx + 3'd1;
      if (r_idx == 3'd7) w_frame_nxt = w_word;
    end else begin
      w_pre_nxt = r_pre + 16'd1;
    end
  end

  always_comb w_nib = w_frame_nxt[{w_idx_nxt, 2'b00} +: 4];

  always_comb begin
    case (w_nib)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      default: w_seg = 7'h0E;
    endcase
  end

`ifdef SHOW_LEADING_ZERO_BLANK_EN
  logic [2:0] w_msd;
  // An all-zero frame leaves w_msd at 0, which keeps digit 0 lit.
  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (w_frame_nxt[4*i +: 4] != 4'h0) w_msd = 3'(i);
    end
    w_blank = (w_idx_nxt > w_msd);
  end
`else
  always_comb w_blank = 1'b0;
`endif

  always_comb begin
    if (s[11])
      w_l_nxt = clkinfo[15:0];
    else begin
      case (select)
        3'd3:    w_l_nxt = signF;
        3'd4:    w_l_nxt = signD;
        3'd5:    w_l_nxt = signE;
        3'd6:    w_l_nxt = signM;
        3'd7:    w_l_nxt = signW;
        default: w_l_nxt = {9'b0, adds};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_live  <= 1'b0;
      r_pre   <= 16'd0;
      r_idx   <= 3'd0;
      r_frame <= 32'd0;
      r_en    <= 8'hFF;
      r_c     <= 7'h7F;
      r_l     <= 16'h0000;
    end else begin
      r_live  <= 1'b1;
      r_pre   <= w_pre_nxt;
      r_idx   <= w_idx_nxt;
      r_frame <= w_frame_nxt;
      r_en    <= w_blank ? 8'hFF : ~(8'b1 << w_idx_nxt);
      r_c     <= w_blank ? 7'h7F : w_seg;
      r_l     <= w_l_nxt;
    end
  end

endmodule

// File: tb/tb_show.sv
// Self-checking bench for show: constant vector tables, hand corner sequences, and random stimulus vs a frame-level model.
module tb_show;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] s;
  logic [31:0] clkinfo, reginfo, meminfo, fetchd, decoded, executed, memoryd, writebackd;
  logic [15:0] signF, signD, signE, signM, signW;

  logic [6:0]  adds1, adds3;
  logic [2:0]  select1, select3;
  logic [15:0] l1, l3;
  logic [7:0]  en1, en3;
  logic [6:0]  c1, c3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  show #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .s(s), .clkinfo(clkinfo), .reginfo(reginfo), .meminfo(meminfo),
    .fetchd(fetchd), .decoded(decoded), .executed(executed), .memoryd(memoryd), .writebackd(writebackd),
    .signF(signF), .signD(signD), .signE(signE), .signM(signM), .signW(signW),
    .adds(adds1), .select(select1), .l(l1), .en(en1), .c(c1));

  show #(.REFRESH_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .s(s), .clkinfo(clkinfo), .reginfo(reginfo), .meminfo(meminfo),
    .fetchd(fetchd), .decoded(decoded), .executed(executed), .memoryd(memoryd), .writebackd(writebackd),
    .signF(signF), .signD(signD), .signE(signE), .signM(signM), .signW(signW),
    .adds(adds3), .select(select3), .l(l3), .en(en3), .c(c3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] hexrom [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          divs [2] = '{1, 3};
  int          m_t [2];
  logic [31:0] m_frame [2];
  logic [7:0]  m_en [2];
  logic [6:0]  m_c [2];
  logic [15:0] m_l;

  function automatic logic [31:0] view_word(input logic [2:0] sel);
    logic [31:0] words [8];
    words = '{clkinfo, reginfo, meminfo, fetchd, decoded, executed, memoryd, writebackd};
    return words[sel];
  endfunction

  function automatic logic [15:0] led_word();
    logic [15:0] signs [5];
    signs = '{signF, signD, signE, signM, signW};
    if (s[11]) return clkinfo[15:0];
    if (s[3:1] >= 3) return signs[s[3:1] - 3];
    return {9'b0, s[10:4]};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_t[k] = 0; m_en[k] = 8'hFF; m_c[k] = 7'h7F;
      end
      m_l = 16'h0000;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int d, top;
        if (m_t[k] % (8 * divs[k]) == 0) m_frame[k] = view_word(s[3:1]);
        d = (m_t[k] / divs[k]) % 8;
        top = 0;
`ifdef SHOW_LEADING_ZERO_BLANK_EN
        for (int n = 0; n < 8; n++) if (((m_frame[k] >> (4 * n)) & 32'hF) != 0) top = n;
`else
        top = 7;
`endif
        if (d > top) begin
          m_en[k] = 8'hFF; m_c[k] = 7'h7F;
        end else begin
          m_en[k] = ~(8'b1 << d);
          m_c[k]  = hexrom[(m_frame[k] >> (4 * d)) & 32'hF];
        end
        m_t[k]++;
      end
      m_l = led_word();
    end
  end

  always @(negedge clk) begin
    chk("model_en1", {24'b0, en1}, {24'b0, m_en[0]});
    chk("model_c1",  {25'b0, c1},  {25'b0, m_c[0]});
    chk("model_en3", {24'b0, en3}, {24'b0, m_en[1]});
    chk("model_c3",  {25'b0, c3},  {25'b0, m_c[1]});
    chk("model_l1",  {16'b0, l1},  {16'b0, m_l});
    chk("model_l3",  {16'b0, l3},  {16'b0, m_l});
  end

  // ---------------- vector tables ----------------
  localparam logic [6:0] LZ = `ifdef SHOW_LEADING_ZERO_BLANK_EN 7'h7F `else 7'h40 `endif;
  localparam logic [7:0] LIT_A3  = `ifdef SHOW_LEADING_ZERO_BLANK_EN 8'h03 `else 8'hFF `endif;
  localparam logic [7:0] LIT_0   = `ifdef SHOW_LEADING_ZERO_BLANK_EN 8'h01 `else 8'hFF `endif;
  localparam logic [7:0] LIT_F5  = `ifdef SHOW_LEADING_ZERO_BLANK_EN 8'h3F `else 8'hFF `endif;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] word;
    logic [55:0] segs;  // {digit7 .. digit0}
    logic [7:0]  lit;
  } disp_t;

  typedef struct {
    logic [11:0] sw;
    logic [31:0] ck;
    logic [15:0] exp_l;
  } led_t;

  disp_t dv [6];
  led_t  lv [4];

  task automatic set_words(input logic [2:0] sel, input logic [31:0] w);
    clkinfo = ~w; reginfo = ~w; meminfo = ~w; fetchd = ~w;
    decoded = ~w; executed = ~w; memoryd = ~w; writebackd = ~w;
    case (sel)
      3'd0: clkinfo = w;
      3'd1: reginfo = w;
      3'd2: meminfo = w;
      3'd3: fetchd = w;
      3'd4: decoded = w;
      3'd5: executed = w;
      3'd6: memoryd = w;
      default: writebackd = w;
    endcase
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("rst_en", {24'b0, en1}, 32'hFF);
      chk("rst_c",  {25'b0, c1},  32'h7F);
      chk("rst_l",  {16'b0, l1},  32'h0);
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_en;
    reset = 1'b1; s = 12'h0;
    set_words(3'd0, 32'h0);
    signF = 16'h1111; signD = 16'h0F0F; signE = 16'h3333; signM = 16'h4444; signW = 16'hA5C3;

    dv[0] = '{3'd3, 32'h8C08_0004, {7'h00, 7'h46, 7'h40, 7'h00, 7'h40, 7'h40, 7'h40, 7'h19}, 8'hFF};
    dv[1] = '{3'd0, 32'h0000_00A3, {LZ, LZ, LZ, LZ, LZ, LZ, 7'h08, 7'h30}, LIT_A3};
    dv[2] = '{3'd2, 32'h0000_0000, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 7'h40}, LIT_0};
    dv[3] = '{3'd6, 32'h89AB_CDEF, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF};
    dv[4] = '{3'd1, 32'h7654_3210, {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFF};
    dv[5] = '{3'd7, 32'h00F0_0000, {LZ, LZ, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, LIT_F5};

    lv[0] = '{12'h2A2, 32'h0001_BEEF, 16'h002A};
    lv[1] = '{12'hAA2, 32'h0001_BEEF, 16'hBEEF};
    lv[2] = '{12'h00E, 32'h0001_BEEF, 16'hA5C3};
    lv[3] = '{12'h008, 32'h0001_BEEF, 16'h0F0F};

    // reset walk with REFRESH_DIV=1: FE, FD, ..., 7F, FE
    do_reset(3);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_en = ~(8'b1 << (i % 8));
      chk("walk_en", {24'b0, en1}, {24'b0, exp_en});
    end

    foreach (dv[v]) begin
      s = {8'h00, dv[v].sel, 1'b0};
      set_words(dv[v].sel, dv[v].word);
      do_reset(1);
      for (int d = 0; d < 8; d++) begin
        @(negedge clk);
        exp_en = dv[v].lit[d] ? ~(8'b1 << d) : 8'hFF;
        chk($sformatf("disp%0d_c%0d", v, d), {25'b0, c1}, {25'b0, dv[v].segs[7*d +: 7]});
        chk($sformatf("disp%0d_en%0d", v, d), {24'b0, en1}, {24'b0, exp_en});
      end
    end

    foreach (lv[v]) begin
      @(negedge clk);
      s = lv[v].sw; clkinfo = lv[v].ck;
      #1;
      chk($sformatf("adds%0d", v), {25'b0, adds1}, {25'b0, lv[v].sw[10:4]});
      chk($sformatf("select%0d", v), {29'b0, select1}, {29'b0, lv[v].sw[3:1]});
      @(negedge clk);
      chk($sformatf("led%0d", v), {16'b0, l1}, {16'b0, lv[v].exp_l});
    end

    // mid-frame data change: current frame keeps the old word
    s = 12'h00A;
    set_words(3'd5, 32'h1234_5678);
    do_reset(1);
    for (int d = 0; d < 16; d++) begin
      logic [6:0] want [16];
      want = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79,
               7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E};
      @(negedge clk);
      chk($sformatf("midframe_c%0d", d), {25'b0, c1}, {25'b0, want[d]});
      if (d == 2) executed = 32'hFFFF_FFFF;
    end

    // mid-frame reset blanks on the next edge
    @(negedge clk); @(negedge clk);
    do_reset(1);

    // random stimulus, checked continuously by the model
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) s = 12'($urandom);
      clkinfo    = $urandom >> $urandom_range(0, 31);
      reginfo    = $urandom >> $urandom_range(0, 31);
      meminfo    = $urandom >> $urandom_range(0, 31);
      fetchd     = $urandom >> $urandom_range(0, 31);
      decoded    = $urandom >> $urandom_range(0, 31);
      executed   = $urandom >> $urandom_range(0, 31);
      memoryd    = $urandom >> $urandom_range(0, 31);
      writebackd = $urandom >> $urandom_range(0, 31);
      signF = 16'($urandom); signD = 16'($urandom); signE = 16'($urandom);
      signM = 16'($urandom); signW = 16'($urandom);
      #1;
      chk("rand_adds", {25'b0, adds3}, {25'b0, s[10:4]});
      chk("rand_select", {29'b0, select3}, {29'b0, s[3:1]});
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
